// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE
  } state_t;

  localparam int unsigned LEN_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// Collects four stream bytes into a little-endian 32-bit word.
module word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] insert;

  // The completed word includes the byte arriving this cycle, so word is
  // presented on the same cycle as the 4th handshake.
  always_comb begin
    insert = shift_q;
    insert[{lane_q, 3'b000} +: 8] = byte_data;
    word       = insert;
    word_valid = byte_fire && (lane_q == 2'(WORD_BYTES - 1));
  end

  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear) begin
      lane_d  = '0;
      shift_d = '0;
    end else if (byte_fire) begin
      lane_d  = lane_q + 2'd1;
      shift_d = insert;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q  <= '0;
      shift_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Fills instruction memory from a framed byte stream and holds the core in
// reset until the frame (length, words, XOR checksum) has been consumed.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error
);

  localparam logic [16:0] DEPTH_W = 17'd1 << ADDR_WIDTH;

  state_t                state_q;
  logic [15:0]           len_q;
  logic [16:0]           word_cnt_q;
  logic [31:0]           acc_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  core_reset_q;
  logic                  done_q;
  logic                  error_q;

  logic        byte_fire;
  logic        asm_fire;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_full;

  assign byte_ready = !reset && (state_q != S_DONE);
  assign byte_fire  = byte_valid && byte_ready;
  assign asm_fire   = byte_fire && (state_q == S_DATA || state_q == S_CSUM);
  assign len_full   = {byte_data, len_q[7:0]};

  word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_q == S_DONE),
    .byte_fire  (asm_fire),
    .byte_data  (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_LEN0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      acc_q        <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_LEN0: if (byte_fire) begin
          len_q[7:0] <= byte_data;
          state_q    <= S_LEN1;
        end
        S_LEN1: if (byte_fire) begin
          len_q[15:8] <= byte_data;
          if ({1'b0, len_full} > DEPTH_W) error_q <= 1'b1;
          state_q <= (len_full == 16'd0) ? S_CSUM : S_DATA;
        end
        S_DATA: if (word_valid) begin
          // acc absorbs the word at the handshake, ahead of the registered
          // write strobe, so checksum bytes may follow with no gap.
          mem_we_q    <= (word_cnt_q < DEPTH_W);
          mem_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
          mem_wdata_q <= word;
          acc_q       <= acc_q ^ word;
          word_cnt_q  <= word_cnt_q + 17'd1;
          if (word_cnt_q + 17'd1 == {1'b0, len_q}) state_q <= S_CSUM;
        end
        S_CSUM: if (word_valid) begin
          if (word != acc_q) error_q <= 1'b1;
          state_q      <= S_DONE;
          done_q       <= 1'b1;
          core_reset_q <= 1'b0;
        end
        S_DONE: if (start) begin
          state_q      <= S_LEN0;
          len_q        <= '0;
          word_cnt_q   <= '0;
          acc_q        <= '0;
          core_reset_q <= 1'b1;
          done_q       <= 1'b0;
          error_q      <= 1'b0;
        end
        default: state_q <= S_LEN0;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader with a small-depth memory (4 words).
module tb_inst_mem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_reset;
  logic          done;
  logic          error;

  inst_mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] frame_words[$];
  int          tests = 0;
  int          fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clock) begin
    if (mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        check("wr_data", mem_wdata, mon_e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int cnt;
    if (gaps && $urandom_range(0, 1) == 1) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clock);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    cnt = 0;
    while (byte_ready !== 1'b1 && cnt < 20) begin
      @(posedge clock); #1;
      cnt++;
    end
    if (cnt >= 20) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int unsigned k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  // Reference: writes go to addresses 0..min(N,DEPTH)-1; error when the
  // supplied checksum differs from the XOR of all words or N exceeds DEPTH.
  task automatic run_frame(input logic [31:0] csum, input bit gaps);
    int          n;
    int          cnt;
    logic [31:0] x;
    bit          exp_err;
    wr_t         w;
    n = frame_words.size();
    x = '0;
    foreach (frame_words[i]) x ^= frame_words[i];
    exp_err = (n > DEPTH) || (csum != x);
    for (int i = 0; i < n && i < DEPTH; i++) begin
      w.addr = AW'(i);
      w.data = frame_words[i];
      exp_q.push_back(w);
    end
    send_byte(8'(n), gaps);
    send_byte(8'(n >> 8), gaps);
    foreach (frame_words[i]) send_word(frame_words[i], gaps);
    send_word(csum, gaps);
    cnt = 0;
    while (done !== 1'b1 && cnt < 10) begin
      @(posedge clock); #1;
      cnt++;
    end
    check("done", 32'(done), 32'd1);
    check("core_reset_released", 32'(core_reset), 32'd0);
    check("error", 32'(error), 32'(exp_err));
    check("byte_ready_in_done", 32'(byte_ready), 32'd0);
    check("writes_outstanding", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("start_core_reset", 32'(core_reset), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
  endtask

  task automatic apply_reset();
    byte_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check("post_rst_byte_ready", 32'(byte_ready), 32'd1);
  endtask

  logic [31:0] xa;

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    apply_reset();

    // Two-word frame, correct checksum, no gaps.
    frame_words = '{32'h0050_0093, 32'h00A0_0113};
    xa = 32'h0050_0093 ^ 32'h00A0_0113;
    run_frame(xa, 1'b0);

    // Same frame, zero checksum.
    pulse_start();
    run_frame(32'h0, 1'b0);

    // Empty frame.
    pulse_start();
    frame_words = {};
    run_frame(32'h0, 1'b0);

    // N exceeds depth: only the first DEPTH words land, error flagged.
    pulse_start();
    frame_words = {};
    for (int i = 0; i < 5; i++) frame_words.push_back($urandom);
    xa = '0;
    foreach (frame_words[i]) xa ^= frame_words[i];
    run_frame(xa, 1'b0);

    // First frame again with random valid gaps.
    pulse_start();
    frame_words = '{32'h0050_0093, 32'h00A0_0113};
    run_frame(32'h0050_0093 ^ 32'h00A0_0113, 1'b1);

    // Reset after three data bytes, then a fresh frame from addr 0.
    pulse_start();
    send_byte(8'd2, 1'b0);
    send_byte(8'd0, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    apply_reset();
    frame_words = '{32'hCAFE_0001, 32'h1234_5678};
    run_frame(32'hCAFE_0001 ^ 32'h1234_5678, 1'b0);

    // Random frames: random length, gaps and checksum corruption.
    for (int f = 0; f < 8; f++) begin
      pulse_start();
      frame_words = {};
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) frame_words.push_back($urandom);
      xa = '0;
      foreach (frame_words[i]) xa ^= frame_words[i];
      if ($urandom_range(0, 1) == 1) xa ^= 32'($urandom_range(1, 255));
      run_frame(xa, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
